// File: rtl/nios_system_avalon_st_packet_arbiter.sv
// -----------------------------------------------------------------------------
// nios_system_avalon_st_packet_arbiter
//
// Merges four Avalon-ST sources onto one output stream. Whole packets are kept
// together, and the sources take turns in round-robin order. The output is a
// single register stage that gives one cycle of latency.
//
// Optional feature macro: AVST_ARB_PROTOCOL_CHECK_EN
//   When it is defined, proto_err is a sticky flag. It sets when a non-SOP beat
//   is accepted in IDLE, or when an SOP beat is accepted in PKT.
//   When it is undefined, proto_err is tied to 0 and no check logic is built.
//
// Ports
//   clk                in   sole clock; all state updates on the rising edge
//   reset              in   synchronous, active-high reset
//   in_valid[3:0]      in   per-source beat valid
//   in_ready[3:0]      out  per-source ready (only the selected source)
//   in_data            in   source i at [i*DATA_W +: DATA_W]
//   in_error           in   source i at [i*ERR_W +: ERR_W]
//   in_startofpacket   in   per-source SOP
//   in_endofpacket     in   per-source EOP
//   out_ready          in   downstream ready
//   out_valid          out  registered beat valid
//   out_data           out  registered beat data
//   out_channel[1:0]   out  index of the source that produced the beat
//   out_error          out  registered beat error
//   out_startofpacket  out  registered SOP
//   out_endofpacket    out  registered EOP
//   busy               out  high while a packet holds the lock (state PKT)
//   proto_err          out  sticky protocol-violation flag
// -----------------------------------------------------------------------------
module nios_system_avalon_st_packet_arbiter #(
  parameter int DATA_W = 32,
  parameter int ERR_W  = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          in_valid,
  output logic [3:0]          in_ready,
  input  logic [4*DATA_W-1:0] in_data,
  input  logic [4*ERR_W-1:0]  in_error,
  input  logic [3:0]          in_startofpacket,
  input  logic [3:0]          in_endofpacket,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          out_channel,
  output logic [ERR_W-1:0]    out_error,
  output logic                out_startofpacket,
  output logic                out_endofpacket,
  output logic                busy,
  output logic                proto_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [1:0]         last_grant_r;
  logic [1:0]         last_grant_nxt_s;
  logic [1:0]         lock_r;
  logic [1:0]         lock_nxt_s;

  logic [1:0]         rr_sel_s;
  logic               rr_found_s;
  logic [1:0]         sel_s;
  logic               sel_ok_s;
  logic               stage_free_s;
  logic               accept_s;
  logic               beat_sop_s;
  logic               beat_eop_s;

  logic               out_valid_r;
  logic [DATA_W-1:0]  out_data_r;
  logic [1:0]         out_channel_r;
  logic [ERR_W-1:0]   out_error_r;
  logic               out_sop_r;
  logic               out_eop_r;

  // The output register can take a new beat when it is empty or being drained.
  assign stage_free_s = !out_valid_r || out_ready;

  // Round-robin scan. The loop walks the candidates from lowest to highest
  // priority, so the last valid candidate written is the first one in scan
  // order (last_grant+1 upward, with wrap).
  always_comb begin
    logic [1:0] cand;
    rr_sel_s   = 2'd0;
    rr_found_s = 1'b0;
    cand       = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = last_grant_r + 2'(k);
      if (in_valid[cand]) begin
        rr_sel_s   = cand;
        rr_found_s = 1'b1;
      end else begin
        rr_sel_s   = rr_sel_s;
        rr_found_s = rr_found_s;
      end
    end
  end

  // Source selection. In IDLE the round-robin winner is selected. In PKT the
  // locked source is selected even while its valid is low, so the lock holds.
  always_comb begin
    sel_s    = rr_sel_s;
    sel_ok_s = 1'b0;
    case (state_r)
      IDLE: begin
        sel_s    = rr_sel_s;
        sel_ok_s = rr_found_s;
      end
      PKT: begin
        sel_s    = lock_r;
        sel_ok_s = 1'b1;
      end
      default: begin
        sel_s    = rr_sel_s;
        sel_ok_s = 1'b0;
      end
    endcase
  end

  // One-hot ready for the selected source. It is held low during reset and
  // while the output stage is stalled.
  always_comb begin
    in_ready = 4'b0000;
    if (!reset && stage_free_s && sel_ok_s) begin
      in_ready[sel_s] = 1'b1;
    end else begin
      in_ready = 4'b0000;
    end
  end

  assign accept_s   = |(in_valid & in_ready);
  assign beat_sop_s = in_startofpacket[sel_s];
  assign beat_eop_s = in_endofpacket[sel_s];

  // Grant FSM next state. A non-SOP beat in IDLE passes through and leaves
  // both the state and the grant history unchanged.
  always_comb begin
    state_nxt_s      = state_r;
    last_grant_nxt_s = last_grant_r;
    lock_nxt_s       = lock_r;
    if (accept_s) begin
      case (state_r)
        IDLE: begin
          if (beat_sop_s && !beat_eop_s) begin
            state_nxt_s = PKT;
            lock_nxt_s  = sel_s;
          end else if (beat_sop_s && beat_eop_s) begin
            last_grant_nxt_s = sel_s;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        PKT: begin
          if (beat_eop_s) begin
            state_nxt_s      = IDLE;
            last_grant_nxt_s = lock_r;
          end else begin
            state_nxt_s = PKT;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Grant FSM state register. Reset makes source 0 the first winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      last_grant_r <= 2'd3;
      lock_r       <= 2'd0;
    end else begin
      state_r      <= state_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      lock_r       <= lock_nxt_s;
    end
  end

  // Output stage register. It loads an accepted beat, empties when it is
  // free and no beat is accepted, and holds while it is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r   <= 1'b0;
      out_data_r    <= '0;
      out_channel_r <= 2'd0;
      out_error_r   <= '0;
      out_sop_r     <= 1'b0;
      out_eop_r     <= 1'b0;
    end else if (stage_free_s) begin
      if (accept_s) begin
        out_valid_r   <= 1'b1;
        out_data_r    <= in_data[sel_s*DATA_W +: DATA_W];
        out_channel_r <= sel_s;
        out_error_r   <= in_error[sel_s*ERR_W +: ERR_W];
        out_sop_r     <= beat_sop_s;
        out_eop_r     <= beat_eop_s;
      end else begin
        out_valid_r   <= 1'b0;
      end
    end
  end

  assign out_valid         = out_valid_r;
  assign out_data          = out_data_r;
  assign out_channel       = out_channel_r;
  assign out_error         = out_error_r;
  assign out_startofpacket = out_sop_r;
  assign out_endofpacket   = out_eop_r;
  assign busy              = (state_r == PKT);

`ifdef AVST_ARB_PROTOCOL_CHECK_EN
  logic proto_err_r;

  // Sticky violation flag. It sets on an SOP-less packet start, or on an SOP
  // that arrives inside a locked packet, and it clears only on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      proto_err_r <= 1'b0;
    end else if (accept_s && (((state_r == IDLE) && !beat_sop_s) ||
                              ((state_r == PKT) && beat_sop_s))) begin
      proto_err_r <= 1'b1;
    end
  end

  assign proto_err = proto_err_r;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_nios_system_avalon_st_packet_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for nios_system_avalon_st_packet_arbiter.
// Directed packet stimulus comes from per-source beat queues. A behavioural
// model (owner/last-grant bookkeeping plus an output slot) is compared with the
// DUT every cycle. Literal channel-order expectations pin the model.
// -----------------------------------------------------------------------------
module tb_nios_system_avalon_st_packet_arbiter;

  localparam int DW = 32;
  localparam int EW = 6;
`ifdef AVST_ARB_PROTOCOL_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      in_valid;
  logic [3:0]      in_ready;
  logic [4*DW-1:0] in_data;
  logic [4*EW-1:0] in_error;
  logic [3:0]      in_startofpacket;
  logic [3:0]      in_endofpacket;
  logic            out_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_channel;
  logic [EW-1:0]   out_error;
  logic            out_startofpacket;
  logic            out_endofpacket;
  logic            busy;
  logic            proto_err;

  always #5 clk = ~clk;

  nios_system_avalon_st_packet_arbiter #(.DATA_W(DW), .ERR_W(EW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_error(in_error), .in_startofpacket(in_startofpacket),
    .in_endofpacket(in_endofpacket), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_channel(out_channel),
    .out_error(out_error), .out_startofpacket(out_startofpacket),
    .out_endofpacket(out_endofpacket), .busy(busy), .proto_err(proto_err)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [EW-1:0] err;
    logic          sop;
    logic          eop;
  } beat_t;

  beat_t    q[4][$];
  logic [3:0] gate;
  int       cap[$];
  int       exp_q[$];
  int       seq_n = 0;
  int       n_cmp = 0;
  int       n_fail = 0;

  // Model state
  bit            model_ok = 1'b0;
  logic          m_valid, m_sop, m_eop, m_proto;
  logic [DW-1:0] m_data;
  logic [EW-1:0] m_err;
  int            m_ch, m_last, m_owner;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_seq(input string nm);
    chk({nm, "_len"}, 64'(cap.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < cap.size()) chk($sformatf("%s_%0d", nm, k), 64'(cap[k]), 64'(exp_q[k]));
    end
  endtask

  task automatic push(input int s, input logic sop, input logic eop);
    beat_t b;
    b.data = {8'(s), 8'(seq_n), 16'hC0DE};
    b.err  = 6'(seq_n);
    b.sop  = sop;
    b.eop  = eop;
    seq_n++;
    q[s].push_back(b);
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (q[i].size() > 0 && gate[i]) begin
        in_valid[i]            = 1'b1;
        in_data[i*DW +: DW]    = q[i][0].data;
        in_error[i*EW +: EW]   = q[i][0].err;
        in_startofpacket[i]    = q[i][0].sop;
        in_endofpacket[i]      = q[i][0].eop;
      end else begin
        in_valid[i]            = 1'b0;
        in_data[i*DW +: DW]    = '0;
        in_error[i*EW +: EW]   = '0;
        in_startofpacket[i]    = 1'b0;
        in_endofpacket[i]      = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    logic [3:0] fire;
    @(negedge clk);
    fire = in_valid & in_ready;
    @(posedge clk);
    #2;
    for (int i = 0; i < 4; i++) begin
      if (fire[i] && q[i].size() > 0) void'(q[i].pop_front());
    end
    drive();
  endtask

  task automatic run(input string nm);
    int n;
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) > 0 && n < 200) begin
      cycle();
      n++;
    end
    chk({nm, "_drain"}, 64'(n < 200), 64'd1);
    cycle();
    cycle();
  endtask

  // Model and per-cycle comparison. The sampling happens on the falling edge.
  always @(negedge clk) begin : model_blk
    int         sel;
    bit         found;
    bit         free;
    logic [3:0] er;
    free  = !m_valid || out_ready;
    found = 1'b0;
    sel   = 0;
    if (m_owner >= 0) begin
      sel = m_owner;
      found = 1'b1;
    end else begin
      for (int j = 1; j <= 4; j++) begin
        if (!found && in_valid[(m_last + j) % 4]) begin
          sel = (m_last + j) % 4;
          found = 1'b1;
        end
      end
    end
    er = (!reset && found && free) ? 4'(1 << sel) : 4'b0000;

    if (model_ok) begin
      chk("in_ready", 64'(in_ready), 64'(er));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("out_data", 64'(out_data), 64'(m_data));
      chk("out_error", 64'(out_error), 64'(m_err));
      chk("out_channel", 64'(out_channel), 64'(m_ch));
      chk("out_sop", 64'(out_startofpacket), 64'(m_sop));
      chk("out_eop", 64'(out_endofpacket), 64'(m_eop));
      chk("busy", 64'(busy), 64'(m_owner >= 0));
      chk("proto_err", 64'(proto_err), 64'(m_proto));
      if (out_valid && out_ready) cap.push_back(int'(out_channel));
    end

    if (reset) begin
      m_valid = 1'b0; m_sop = 1'b0; m_eop = 1'b0; m_proto = 1'b0;
      m_data = '0; m_err = '0; m_ch = 0; m_last = 3; m_owner = -1;
      model_ok = 1'b1;
    end else if (free) begin
      if (found && in_valid[sel]) begin
        m_valid = 1'b1;
        m_data  = in_data[sel*DW +: DW];
        m_err   = in_error[sel*EW +: EW];
        m_ch    = sel;
        m_sop   = in_startofpacket[sel];
        m_eop   = in_endofpacket[sel];
        if (m_owner < 0) begin
          if (!m_sop) begin
            if (PCHK) m_proto = 1'b1;
          end else if (m_eop) begin
            m_last = sel;
          end else begin
            m_owner = sel;
          end
        end else begin
          if (m_sop && PCHK) m_proto = 1'b1;
          if (m_eop) begin
            m_last = m_owner;
            m_owner = -1;
          end
        end
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    out_ready = 1'b1;
    gate = 4'hF;
    in_valid = '0; in_data = '0; in_error = '0;
    in_startofpacket = '0; in_endofpacket = '0;
    repeat (3) cycle();
    reset = 1'b0;
    cycle();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_channel", 64'(out_channel), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_proto", 64'(proto_err), 64'd0);

    // Round robin over four single-beat sources
    for (int k = 0; k < 2; k++) for (int s = 0; s < 4; s++) push(s, 1'b1, 1'b1);
    drive(); cap.delete();
    run("rr");
    exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk_seq("rr_order");

    // Packet lock: source 2 sends 5 beats while source 0 waits
    cap.delete();
    push(1, 1'b1, 1'b1); drive(); run("lock_pre");
    push(2, 1'b1, 1'b0); push(2, 1'b0, 1'b0); push(2, 1'b0, 1'b0);
    push(2, 1'b0, 1'b0); push(2, 1'b0, 1'b1); push(0, 1'b1, 1'b1);
    drive(); run("lock");
    exp_q = '{1, 2, 2, 2, 2, 2, 0};
    chk_seq("lock_order");

    // Backpressure: 3 stalled cycles mid-packet
    push(3, 1'b1, 1'b0); push(3, 1'b0, 1'b0); push(3, 1'b0, 1'b1); push(0, 1'b1, 1'b1);
    drive(); cap.delete();
    cycle();
    out_ready = 1'b0;
    #1;
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    repeat (3) cycle();
    out_ready = 1'b1;
    run("bp");
    exp_q = '{3, 3, 3, 0};
    chk_seq("bp_order");

    // Locked source drops valid mid-packet; source 2 must wait
    push(1, 1'b1, 1'b0); push(1, 1'b0, 1'b0); push(1, 1'b0, 1'b0); push(1, 1'b0, 1'b1);
    push(2, 1'b1, 1'b1);
    drive(); cap.delete();
    cycle(); cycle();
    gate = 4'b1101; drive();
    repeat (3) cycle();
    chk("gap_busy", 64'(busy), 64'd1);
    chk("gap_in_ready", 64'(in_ready), 64'b0010);
    gate = 4'hF; drive();
    run("gap");
    exp_q = '{1, 1, 1, 1, 2};
    chk_seq("gap_order");

    // SOP repeated inside a locked packet
    push(3, 1'b1, 1'b0); push(3, 1'b1, 1'b0); push(3, 1'b0, 1'b1);
    drive(); cap.delete();
    run("midsop");
    chk("midsop_proto", 64'(proto_err), 64'(PCHK));
    chk("midsop_busy", 64'(busy), 64'd0);

    // Non-SOP beat in IDLE: forwarded, grant history unchanged
    push(0, 1'b0, 1'b0); drive();
    run("nosop");
    chk("nosop_busy", 64'(busy), 64'd0);
    push(0, 1'b1, 1'b1); push(1, 1'b1, 1'b1); drive();
    run("nosop_post");
    exp_q = '{3, 3, 3, 0, 0, 1};
    chk_seq("nosop_order");

    // Reset in the middle of a 4-beat packet from source 1
    push(1, 1'b1, 1'b0); push(1, 1'b0, 1'b0); push(1, 1'b0, 1'b0); push(1, 1'b0, 1'b1);
    drive();
    cycle(); cycle();
    reset = 1'b1;
    q[1].delete();
    push(0, 1'b1, 1'b1); push(1, 1'b1, 1'b1);
    drive();
    #1;
    chk("rstmid_in_ready", 64'(in_ready), 64'd0);
    cycle();
    reset = 1'b0;
    #1;
    chk("rstmid_out_valid", 64'(out_valid), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_proto", 64'(proto_err), 64'd0);
    cap.delete();
    run("rstmid");
    exp_q = '{0, 1};
    chk_seq("rstmid_order");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nios_system_avalon_st_packet_arbiter.md
NIOS_SYSTEM_AVALON_ST_PACKET_ARBITER -- requirements
Module: nios_system_avalon_st_packet_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, per-beat data width of every input and the output.
REQ-002 Parameter ERR_W, default 6, per-beat error width of every input and the output.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  4  per-source beat valid; bit i belongs to source i.
REQ-006 in_ready  output  4  per-source ready; a beat transfers when in_valid[i] and in_ready[i] are both high.
REQ-007 in_data  input  4*DATA_W  source i occupies bits [i*DATA_W +: DATA_W].
REQ-008 in_error  input  4*ERR_W  source i occupies bits [i*ERR_W +: ERR_W].
REQ-009 in_startofpacket  input  4  per-source SOP.
REQ-010 in_endofpacket  input  4  per-source EOP.
REQ-011 out_ready  input  1  downstream ready.
REQ-012 out_valid  output  1  registered output valid.
REQ-013 out_data  output  DATA_W  registered beat data.
REQ-014 out_channel  output  2  index of the source that produced the beat.
REQ-015 out_error  output  ERR_W  registered beat error.
REQ-016 out_startofpacket  output  1  registered SOP.
REQ-017 out_endofpacket  output  1  registered EOP.
REQ-018 busy  output  1  high while in state PKT.
REQ-019 proto_err  output  1  sticky protocol-violation flag; see REQ-036.

Function
REQ-020 The block SHALL merge four Avalon-ST sources onto one stream, packet-atomically, with round-robin fairness.
REQ-021 The output stage SHALL be one register; stage_free = !out_valid || out_ready.
REQ-022 in_ready[i] SHALL be high only for the selected source sel, and only when stage_free is high; all other bits SHALL be low.
REQ-023 On an accepted beat, the output registers SHALL load the beat next edge with out_channel=sel, giving 1-cycle latency.
REQ-024 When stage_free is high and no beat is accepted, out_valid SHALL clear; when stage_free is low, the output registers SHALL hold unchanged.
REQ-025 State IDLE: sel SHALL be the first valid source scanning (last_grant+1) mod 4 upward with wrap; with no valid source, nothing is accepted.
REQ-026 In IDLE, accepting a beat with SOP=1 and EOP=0 SHALL load lock=sel and move to PKT.
REQ-027 In IDLE, accepting a beat with SOP=1 and EOP=1 (single-beat packet) SHALL stay in IDLE and set last_grant=sel.
REQ-028 State PKT: sel SHALL equal lock regardless of other valids, and the other sources SHALL stall.
REQ-029 In PKT, accepting a beat with EOP=1 SHALL set last_grant=lock and return to IDLE; the next arbitration SHALL occur in the following cycle.
REQ-030 In PKT, a locked source deasserting valid mid-packet SHALL keep the lock; there is no timeout.
REQ-031 If out_ready is low while out_valid is high, no source SHALL be readied that cycle, and the grant state SHALL not advance.
REQ-032 A beat arriving in IDLE without SOP SHALL still be forwarded as a single beat; state and last_grant SHALL be unchanged.

Reset
REQ-033 While reset is high at a clock edge, the block SHALL clear out_valid, out_startofpacket, out_endofpacket and proto_err, and set the state to IDLE.
REQ-034 Reset SHALL set last_grant=3, so source 0 has first priority; it SHALL clear out_data, out_error and out_channel to 0.
REQ-035 Reset asserted mid-packet SHALL abandon the packet with no EOP emitted; in_ready SHALL be 0 during reset.

Configuration
REQ-036 With AVST_ARB_PROTOCOL_CHECK_EN defined, proto_err SHALL set on either violation: a non-SOP beat accepted in IDLE, or an SOP beat accepted in PKT. It SHALL hold until reset.
REQ-037 Without AVST_ARB_PROTOCOL_CHECK_EN, proto_err SHALL be tied to 0 and no check logic SHALL be present.

Verification
REQ-038 Round-robin: after reset, all four sources continuously send single-beat packets with out_ready=1 -> out_channel sequence 0,1,2,3,0,1,... with one beat per cycle.
REQ-039 Packet lock: source 2 sends a 5-beat packet while source 0 is valid -> five consecutive beats with out_channel=2, then source 0 next.
REQ-040 Backpressure: hold out_ready=0 for 3 cycles while out_valid=1 -> outputs stable, in_ready=0, no beat lost or duplicated after release.
REQ-041 Reset mid-packet: assert reset on beat 2 of a 4-beat packet from source 1 -> next cycle out_valid=0 and busy=0; after reset, source 0 wins first.
REQ-042 With AVST_ARB_PROTOCOL_CHECK_EN defined, send an SOP from the locked source mid-packet -> proto_err=1 and it stays 1; the same stimulus without the macro -> proto_err=0.
